// File: rtl/axi_wr_route_ctrl.sv
// Write-path routing controller for a 1-master / 2-slave AXI interconnect.
// Decodes each AW address to a slave and drives the select/enable inputs of the
// AW and W enable-demuxes. Only one AW/W burst is in flight at a time. B
// responses are steered back in AW order through a small FIFO of route bits.
module axi_wr_route_ctrl #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] SLAVE1_BASE = 32'h4000_0000,
   parameter logic [ADDR_WIDTH-1:0] SLAVE1_MASK = 32'hC000_0000,
   parameter int                    MAX_OUTST   = 4
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic [ADDR_WIDTH-1:0] S_AWADDR,
   input  logic                  S_AWVALID,
   output logic                  S_AWREADY,
   input  logic                  S_WVALID,
   input  logic                  S_WLAST,
   output logic                  S_WREADY,
   output logic                  S_BVALID,
   input  logic                  S_BREADY,
   output logic                  M0_AWVALID,
   output logic                  M1_AWVALID,
   input  logic                  M0_AWREADY,
   input  logic                  M1_AWREADY,
   output logic                  M0_WVALID,
   output logic                  M1_WVALID,
   input  logic                  M0_WREADY,
   input  logic                  M1_WREADY,
   input  logic                  M0_BVALID,
   input  logic                  M1_BVALID,
   output logic                  M0_BREADY,
   output logic                  M1_BREADY,
   output logic                  aw_sel,
   output logic                  aw_en,
   output logic                  w_sel,
   output logic                  w_en,
   output logic                  b_sel
);

   localparam int PW = $clog2(MAX_OUTST);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t          state_q, state_d;
   logic            route_q;
   logic            aw_dec;
   logic            aw_accept;
   logic            push, pop;
   logic            fifo_full, fifo_empty;
   logic            fifo_mem [MAX_OUTST];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;

   assign aw_dec     = ((S_AWADDR & SLAVE1_MASK) == SLAVE1_BASE);
   assign fifo_full  = (count == CW'(MAX_OUTST));
   assign fifo_empty = (count == '0);
   // Full is judged on the registered count, so a same-cycle pop never unblocks accept.
   assign aw_accept  = (state_q == IDLE) && S_AWVALID && !fifo_full;
   assign push       = (state_q == ADDR) && S_AWVALID &&
                       (route_q ? M1_AWREADY : M0_AWREADY);

   // FSM state register.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state and AW/W gating; everything idles low unless its phase is active.
   always_comb begin
      state_d    = state_q;
      aw_en      = 1'b0;
      aw_sel     = 1'b0;
      M0_AWVALID = 1'b0;
      M1_AWVALID = 1'b0;
      S_AWREADY  = 1'b0;
      w_en       = 1'b0;
      w_sel      = 1'b0;
      M0_WVALID  = 1'b0;
      M1_WVALID  = 1'b0;
      S_WREADY   = 1'b0;
      case (state_q)
         IDLE: begin
            if (aw_accept) state_d = ADDR;
         end
         ADDR: begin
            aw_en      = 1'b1;
            aw_sel     = route_q;
            M0_AWVALID = S_AWVALID && !route_q;
            M1_AWVALID = S_AWVALID &&  route_q;
            S_AWREADY  = route_q ? M1_AWREADY : M0_AWREADY;
            if (push) state_d = DATA;
         end
         DATA: begin
            w_en      = 1'b1;
            w_sel     = route_q;
            M0_WVALID = S_WVALID && !route_q;
            M1_WVALID = S_WVALID &&  route_q;
            S_WREADY  = route_q ? M1_WREADY : M0_WREADY;
            if (S_WVALID && S_WLAST && (route_q ? M1_WREADY : M0_WREADY))
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Route of the burst in flight, captured when the AW is accepted in IDLE.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)       route_q <= 1'b0;
      else if (aw_accept) route_q <= aw_dec;
   end

   // B-route storage; contents are only meaningful below count, so no reset.
   always_ff @(posedge ACLK) begin
      if (push) fifo_mem[wr_ptr] <= route_q;
   end

   // FIFO pointers wrap naturally (power-of-2 depth); push+pop leaves count unchanged.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // B steering from the FIFO head; the non-selected slave's BVALID simply waits.
   always_comb begin
      b_sel     = 1'b0;
      S_BVALID  = 1'b0;
      M0_BREADY = 1'b0;
      M1_BREADY = 1'b0;
      if (!fifo_empty) begin
         b_sel     = fifo_mem[rd_ptr];
         S_BVALID  = b_sel ? M1_BVALID : M0_BVALID;
         M0_BREADY = !b_sel && S_BREADY;
         M1_BREADY =  b_sel && S_BREADY;
      end
   end

   assign pop = S_BVALID && S_BREADY;

endmodule

// File: tb/tb_axi_wr_route_ctrl.sv
// Directed bench for axi_wr_route_ctrl: a table of single bursts with full
// handshake checks, then hand-written sequences for FIFO-full blocking, B
// ordering, simultaneous push/pop and reset in the middle of a burst.
module tb_axi_wr_route_ctrl;

   logic        ACLK;
   logic        ARESETN;
   logic [31:0] S_AWADDR;
   logic        S_AWVALID, S_AWREADY;
   logic        S_WVALID, S_WLAST, S_WREADY;
   logic        S_BVALID, S_BREADY;
   logic        M0_AWVALID, M1_AWVALID, M0_AWREADY, M1_AWREADY;
   logic        M0_WVALID, M1_WVALID, M0_WREADY, M1_WREADY;
   logic        M0_BVALID, M1_BVALID, M0_BREADY, M1_BREADY;
   logic        aw_sel, aw_en, w_sel, w_en, b_sel;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] addr;
      int          beats;
      logic        sel;
   } vec_t;

   vec_t tbl [5];

   axi_wr_route_ctrl dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
      .S_WVALID(S_WVALID), .S_WLAST(S_WLAST), .S_WREADY(S_WREADY),
      .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
      .M0_AWVALID(M0_AWVALID), .M1_AWVALID(M1_AWVALID),
      .M0_AWREADY(M0_AWREADY), .M1_AWREADY(M1_AWREADY),
      .M0_WVALID(M0_WVALID), .M1_WVALID(M1_WVALID),
      .M0_WREADY(M0_WREADY), .M1_WREADY(M1_WREADY),
      .M0_BVALID(M0_BVALID), .M1_BVALID(M1_BVALID),
      .M0_BREADY(M0_BREADY), .M1_BREADY(M1_BREADY),
      .aw_sel(aw_sel), .aw_en(aw_en), .w_sel(w_sel), .w_en(w_en), .b_sel(b_sel)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want test end");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   // Unchecked burst from IDLE with both slaves always ready.
   task automatic aw_w(input logic [31:0] addr, input int beats);
      S_AWADDR  = addr;
      S_AWVALID = 1'b1;
      step();
      step();
      S_AWVALID = 1'b0;
      S_WVALID  = 1'b1;
      for (int i = 0; i < beats; i++) begin
         S_WLAST = (i == beats - 1);
         step();
      end
      S_WVALID = 1'b0;
      S_WLAST  = 1'b0;
   endtask

   // Checked burst plus its B response.
   task automatic run_vec(input vec_t r, input int idx);
      string p;
      p = $sformatf("v%0d_", idx);
      S_AWADDR  = r.addr;
      S_AWVALID = 1'b1;
      #1;
      chk({p, "idle_awready"}, S_AWREADY, 0);
      chk({p, "idle_aw_en"}, aw_en, 0);
      step();
      chk({p, "aw_en"}, aw_en, 1);
      chk({p, "aw_sel"}, aw_sel, r.sel);
      chk({p, "m1_awvalid"}, M1_AWVALID, r.sel);
      chk({p, "m0_awvalid"}, M0_AWVALID, !r.sel);
      chk({p, "s_awready"}, S_AWREADY, 1);
      step();
      S_AWVALID = 1'b0;
      S_WVALID  = 1'b1;
      for (int i = 0; i < r.beats; i++) begin
         S_WLAST = (i == r.beats - 1);
         #1;
         chk({p, $sformatf("w_en_b%0d", i)}, w_en, 1);
         chk({p, $sformatf("w_sel_b%0d", i)}, w_sel, r.sel);
         chk({p, $sformatf("m1_wvalid_b%0d", i)}, M1_WVALID, r.sel);
         chk({p, $sformatf("m0_wvalid_b%0d", i)}, M0_WVALID, !r.sel);
         chk({p, $sformatf("aw_idle_b%0d", i)}, {aw_en, M0_AWVALID, M1_AWVALID}, 0);
         step();
      end
      S_WVALID = 1'b0;
      S_WLAST  = 1'b0;
      #1;
      chk({p, "post_w_en"}, w_en, 0);
      chk({p, "post_wready"}, S_WREADY, 0);
      chk({p, "b_sel_head"}, b_sel, r.sel);
      chk({p, "bvalid_wait"}, S_BVALID, 0);
      if (r.sel) M1_BVALID = 1'b1;
      else       M0_BVALID = 1'b1;
      S_BREADY = 1'b1;
      #1;
      chk({p, "s_bvalid"}, S_BVALID, 1);
      chk({p, "m1_bready"}, M1_BREADY, r.sel);
      chk({p, "m0_bready"}, M0_BREADY, !r.sel);
      step();
      M0_BVALID = 1'b0;
      M1_BVALID = 1'b0;
      S_BREADY  = 1'b0;
      #1;
      chk({p, "b_empty"}, S_BVALID, 0);
      chk({p, "b_sel_empty"}, b_sel, 0);
   endtask

   initial begin
      tbl[0] = '{addr: 32'h4000_0010, beats: 4, sel: 1'b1};
      tbl[1] = '{addr: 32'h0000_0100, beats: 1, sel: 1'b0};
      tbl[2] = '{addr: 32'h7FFF_FFFF, beats: 2, sel: 1'b1};
      tbl[3] = '{addr: 32'hC000_0000, beats: 1, sel: 1'b0};
      tbl[4] = '{addr: 32'h8000_0040, beats: 3, sel: 1'b0};

      // Reset with inputs active: every output must still be low.
      ARESETN    = 1'b0;
      S_AWADDR   = 32'h4000_0000;
      S_AWVALID  = 1'b1;
      S_WVALID   = 1'b1;
      S_WLAST    = 1'b1;
      S_BREADY   = 1'b1;
      M0_AWREADY = 1'b1;
      M1_AWREADY = 1'b1;
      M0_WREADY  = 1'b1;
      M1_WREADY  = 1'b1;
      M0_BVALID  = 1'b1;
      M1_BVALID  = 1'b1;
      #12;
      chk("rst_ready", {S_AWREADY, S_WREADY, S_BVALID}, 0);
      chk("rst_awvalid", {M0_AWVALID, M1_AWVALID}, 0);
      chk("rst_wvalid", {M0_WVALID, M1_WVALID}, 0);
      chk("rst_bready", {M0_BREADY, M1_BREADY}, 0);
      chk("rst_en_sel", {aw_en, aw_sel, w_en, w_sel, b_sel}, 0);
      S_AWVALID = 1'b0;
      S_WVALID  = 1'b0;
      S_WLAST   = 1'b0;
      S_BREADY  = 1'b0;
      M0_BVALID = 1'b0;
      M1_BVALID = 1'b0;
      #5;
      ARESETN = 1'b1;
      step();

      // Table of single bursts (T1, T2 and decode corners).
      for (int i = 0; i < 5; i++) run_vec(tbl[i], i);

      // T3: four outstanding AWs fill the FIFO; a fifth must not be acked.
      aw_w(32'h4000_0000, 1);
      aw_w(32'h0000_0000, 1);
      aw_w(32'h4000_0004, 2);
      aw_w(32'h0000_0004, 1);
      S_AWADDR  = 32'h4000_0100;
      S_AWVALID = 1'b1;
      step();
      step();
      chk("full_aw_en", aw_en, 0);
      chk("full_awready", S_AWREADY, 0);
      chk("full_awvalid", {M0_AWVALID, M1_AWVALID}, 0);
      chk("full_head", b_sel, 1);

      // T4: M0 response waits behind M1 at the head.
      M0_BVALID = 1'b1;
      S_BREADY  = 1'b1;
      #1;
      chk("t4_m0_bready_blk", M0_BREADY, 0);
      chk("t4_bvalid_blk", S_BVALID, 0);
      M1_BVALID = 1'b1;
      #1;
      chk("t4_m1_bvalid", S_BVALID, 1);
      chk("t4_m1_bready", M1_BREADY, 1);
      chk("t4_m0_bready", M0_BREADY, 0);
      step();
      M1_BVALID = 1'b0;
      #1;
      chk("t4_samecyc_pop_no_accept", aw_en, 0);
      chk("t4_head0", b_sel, 0);
      chk("t4_m0_pass", S_BVALID, 1);
      chk("t4_m0_bready", M0_BREADY, 1);
      step();
      M0_BVALID = 1'b0;
      S_BREADY  = 1'b0;
      #1;
      chk("t3_5th_accepted", aw_en, 1);
      chk("t3_5th_sel", aw_sel, 1);
      step();
      S_AWVALID = 1'b0;
      S_WVALID  = 1'b1;
      S_WLAST   = 1'b1;
      step();
      S_WVALID  = 1'b0;
      S_WLAST   = 1'b0;
      #1;
      chk("t3_head_after", b_sel, 1);

      // T5: bring count to 2 (routes 0,1), then push and pop together.
      M1_BVALID = 1'b1;
      S_BREADY  = 1'b1;
      step();
      M1_BVALID = 1'b0;
      S_BREADY  = 1'b0;
      #1;
      chk("t5_head0", b_sel, 0);
      S_AWADDR  = 32'h0000_0200;
      S_AWVALID = 1'b1;
      step();
      M0_BVALID = 1'b1;
      S_BREADY  = 1'b1;
      #1;
      chk("t5_bvalid", S_BVALID, 1);
      chk("t5_awready", S_AWREADY, 1);
      step();
      S_AWVALID = 1'b0;
      M0_BVALID = 1'b0;
      S_BREADY  = 1'b0;
      S_WVALID  = 1'b1;
      S_WLAST   = 1'b1;
      #1;
      chk("t5_head1", b_sel, 1);
      chk("t5_w_sel", w_sel, 0);
      step();
      S_WVALID  = 1'b0;
      S_WLAST   = 1'b0;
      M0_BVALID = 1'b1;
      M1_BVALID = 1'b1;
      S_BREADY  = 1'b1;
      #1;
      chk("t5_drain1_sel", b_sel, 1);
      chk("t5_drain1_bready", {M1_BREADY, M0_BREADY}, 2'b10);
      step();
      chk("t5_drain2_sel", b_sel, 0);
      chk("t5_drain2_bready", {M1_BREADY, M0_BREADY}, 2'b01);
      step();
      chk("t5_empty_bvalid", S_BVALID, 0);
      chk("t5_empty_bready", {M1_BREADY, M0_BREADY}, 0);
      M0_BVALID = 1'b0;
      M1_BVALID = 1'b0;
      S_BREADY  = 1'b0;

      // T6: reset during beat 2 of a 4-beat burst to slave 1.
      S_AWADDR  = 32'h4000_0000;
      S_AWVALID = 1'b1;
      step();
      step();
      S_AWVALID = 1'b0;
      S_WVALID  = 1'b1;
      S_WLAST   = 1'b0;
      step();
      step();
      M1_BVALID = 1'b1;
      #1;
      chk("t6_pre_w_en", w_en, 1);
      chk("t6_pre_m1_wvalid", M1_WVALID, 1);
      chk("t6_pre_bvalid", S_BVALID, 1);
      ARESETN = 1'b0;
      #1;
      chk("t6_rst_w", {w_en, w_sel, M1_WVALID, M0_WVALID, S_WREADY}, 0);
      chk("t6_rst_b", {S_BVALID, b_sel, M1_BREADY, M0_BREADY}, 0);
      chk("t6_rst_aw", {aw_en, aw_sel, S_AWREADY}, 0);
      S_WVALID = 1'b0;
      #3;
      ARESETN = 1'b1;
      step();
      chk("t6_fifo_empty", S_BVALID, 0);
      chk("t6_idle", {aw_en, w_en}, 0);
      M1_BVALID = 1'b0;
      S_AWADDR  = 32'h0000_0000;
      S_AWVALID = 1'b1;
      step();
      chk("t6_accept_after", aw_en, 1);
      chk("t6_sel_after", aw_sel, 0);
      step();
      S_AWVALID = 1'b0;
      S_WVALID  = 1'b1;
      S_WLAST   = 1'b1;
      step();
      S_WVALID  = 1'b0;
      S_WLAST   = 1'b0;
      #1;
      chk("t6_final_idle", {aw_en, w_en}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
